// File: rtl/in_coin_capture.sv
// Avalon-MM input PIO for the vending panel coin/key lines: synchronizes, debounces and
// captures selected edges per bit, with a W1C capture register and a masked level interrupt.
module in_coin_capture #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned CNT_W           = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] readdata,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] db_q, db_dly_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [WIDTH-1:0] edge_cap_q, irq_mask_q;
    logic             irq_q;

    logic             wr_en;
    logic [WIDTH-1:0] edge_ev;
    logic [WIDTH-1:0] cap_clr;

    assign wr_en   = chipselect & ~write_n;
    assign cap_clr = (wr_en && address == 2'd3) ? writedata : '0;
    assign irq     = irq_q;

    always_comb begin
        edge_ev = '0;
        case (EDGE_TYPE)
            0:       edge_ev = db_q & ~db_dly_q;
            1:       edge_ev = ~db_q & db_dly_q;
            default: edge_ev = db_q ^ db_dly_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= in_port;
            sync2_q  <= sync1_q;
            db_dly_q <= db_q;
            // Counter only runs while the synchronized line disagrees with db.
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CntMax) begin
                    db_q[i]  <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap_q <= '0;
            irq_mask_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            // A new event in the same cycle as a clear keeps the bit set.
            edge_cap_q <= (edge_cap_q & ~cap_clr) | edge_ev;
            if (wr_en && address == 2'd2) begin
                irq_mask_q <= writedata;
            end
            irq_q <= |(edge_cap_q & irq_mask_q);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = db_q;
            2'd2:    readdata = irq_mask_q;
            2'd3:    readdata = edge_cap_q;
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_in_coin_capture.sv
// Bench for in_coin_capture: three instances (rise/fall/any) on a shared bus and input lines,
// checked every cycle against a window-based reference model, plus directed scenarios.
module tb_in_coin_capture;

    localparam int W  = 4;
    localparam int DB = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [W-1:0] writedata;
    logic [W-1:0] in_port;
    logic [W-1:0] rd [3];
    logic         irq_o [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        in_coin_capture #(
            .WIDTH          (W),
            .DEBOUNCE_CYCLES(DB),
            .EDGE_TYPE      (g),
            .CNT_W          (5)
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .address   (address),
            .chipselect(chipselect),
            .write_n   (write_n),
            .writedata (writedata),
            .in_port   (in_port),
            .readdata  (rd[g]),
            .irq       (irq_o[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [W-1:0] m_s1, m_s2, m_db, m_dbd;
    logic [W-1:0] m_mask [3];
    logic [W-1:0] m_edge [3];
    logic         m_irq  [3];
    logic [W-1:0] hist [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_dbd = '0;
        for (int t = 0; t < 3; t++) begin
            m_mask[t] = '0; m_edge[t] = '0; m_irq[t] = 1'b0;
        end
        hist.delete();
    endtask

    function automatic logic [W-1:0] exp_rd(input int t, input int a);
        case (a)
            0:       return m_db;
            2:       return m_mask[t];
            3:       return m_edge[t];
            default: return '0;
        endcase
    endfunction

    // Advance the model by one clock edge using the bus/line values present before the edge.
    // db flips once the last DB synchronized samples all disagree with it.
    task automatic model_edge();
        logic [W-1:0] ev, clr, new_db;
        logic         we, all_diff;
        if (!reset_n) begin
            model_reset();
            return;
        end
        we  = chipselect && !write_n;
        clr = (we && address == 2'd3) ? writedata : '0;
        for (int t = 0; t < 3; t++) begin
            ev = (t == 0) ? (m_db & ~m_dbd) : (t == 1) ? (~m_db & m_dbd) : (m_db ^ m_dbd);
            m_irq[t]  = |(m_edge[t] & m_mask[t]);
            m_edge[t] = (m_edge[t] & ~clr) | ev;
            if (we && address == 2'd2) m_mask[t] = writedata;
        end
        hist.push_front(m_s2);
        if (hist.size() > DB) void'(hist.pop_back());
        new_db = m_db;
        if (hist.size() == DB) begin
            for (int i = 0; i < W; i++) begin
                all_diff = 1'b1;
                foreach (hist[k]) if (hist[k][i] == m_db[i]) all_diff = 1'b0;
                if (all_diff) new_db[i] = ~m_db[i];
            end
        end
        m_dbd = m_db;
        m_db  = new_db;
        m_s2  = m_s1;
        m_s1  = in_port;
    endtask

    task automatic step();
        logic [1:0] sv;
        @(posedge clk);
        model_edge();
        #1;
        sv = address;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            for (int t = 0; t < 3; t++) begin
                check_eq($sformatf("rd_t%0d_a%0d", t, a), 32'(rd[t]), 32'(exp_rd(t, a)));
            end
        end
        for (int t = 0; t < 3; t++) check_eq($sformatf("irq_t%0d", t), 32'(irq_o[t]), 32'(m_irq[t]));
        address = sv;
    endtask

    task automatic bus_idle();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [W-1:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step();
        bus_idle();
        address = 2'd0;
    endtask

    task automatic clean_reset(input logic [W-1:0] lines);
        reset_n = 1'b0;
        in_port = lines;
        bus_idle();
        model_reset();
        repeat (2) step();
        reset_n = 1'b1;
    endtask

    task automatic peek(input string tag, input int t, input logic [1:0] a, input logic [W-1:0] exp);
        logic [1:0] sv;
        sv = address;
        address = a;
        #1;
        check_eq(tag, 32'(rd[t]), 32'(exp));
        address = sv;
    endtask

    initial begin
        reset_n = 1'b0; address = 2'd0; writedata = '0; in_port = '0;
        bus_idle();
        model_reset();

        // Reset values with lines high, then debounce latency
        clean_reset(4'hF);
        for (int a = 0; a < 4; a++) peek($sformatf("rst_a%0d", a), 0, 2'(a), 4'h0);
        address = 2'd0;
        for (int n = 1; n <= 18; n++) begin
            step();
            if (n == 17) peek("lat17_db", 0, 2'd0, 4'h0);
            if (n == 18) peek("lat18_db", 0, 2'd0, 4'hF);
        end
        repeat (2) step();
        peek("cap_rise", 0, 2'd3, 4'hF);
        peek("cap_fall", 1, 2'd3, 4'h0);
        peek("cap_any",  2, 2'd3, 4'hF);
        check_eq("irq_masked", 32'(irq_o[0]), 32'd0);

        // Glitch rejection and qualified rise
        clean_reset(4'h0);
        in_port = 4'b0010;
        repeat (10) step();
        in_port = 4'b0000;
        repeat (24) step();
        peek("glitch_db",  0, 2'd0, 4'h0);
        peek("glitch_cap", 0, 2'd3, 4'h0);
        in_port = 4'b0010;
        repeat (22) step();
        peek("hold_db",  0, 2'd0, 4'b0010);
        peek("hold_cap", 0, 2'd3, 4'b0010);

        // Interrupt path: unmask pending capture, then W1C clear
        write_reg(2'd2, 4'b0010);
        step();
        check_eq("irq_unmask", 32'(irq_o[0]), 32'd1);
        write_reg(2'd3, 4'b0010);
        step();
        check_eq("irq_clear", 32'(irq_o[0]), 32'd0);
        peek("cap_clear", 0, 2'd3, 4'h0);

        // Set/clear collision on bit 2: capture sets at edge 19 after release
        clean_reset(4'h0);
        in_port = 4'b0100;
        repeat (18) step();
        address = 2'd3; writedata = 4'b0100; chipselect = 1'b1; write_n = 1'b0;
        step();
        bus_idle();
        peek("collide_cap", 0, 2'd3, 4'b0100);

        // Randomized traffic, with one asynchronous reset in the middle
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(15) == 0) in_port = in_port ^ W'(1 << $urandom_range(W - 1));
            if ($urandom_range(3) == 0) begin
                chipselect = 1'($urandom); write_n = 1'($urandom);
                address = 2'($urandom); writedata = W'($urandom);
            end else begin
                bus_idle();
            end
            if (c == 1500) reset_n = 1'b0;
            if (c == 1503) reset_n = 1'b1;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
